// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The word count is 9 bits wide so that a count byte of 0 can stand for 256 words.
package imem_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         CNT_W     = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        DATA  = 3'd2,
        CHECK = 3'd3,
        ERR   = 3'd4
    } state_t;

    // A count byte of 0 encodes the full 256-word index space.
    function automatic logic [CNT_W-1:0] decode_count(input logic [7:0] b);
        return (b == 8'd0) ? 9'd256 : {1'b0, b};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and IMEM write / status outputs of the loader.
// rx_valid is a one-cycle strobe with no back-pressure; imem_we is a one-cycle write with no ready.
interface imem_loader_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_busy;
    logic        load_done;
    logic        load_error;

    modport master (
        input  rx_data, rx_valid,
        output imem_we, imem_addr, imem_wdata,
        output cpu_hold, load_busy, load_done, load_error
    );

    modport slave (
        output rx_data, rx_valid,
        input  imem_we, imem_addr, imem_wdata,
        input  cpu_hold, load_busy, load_done, load_error
    );

endinterface

// File: rtl/imem_loader_packer.sv
// Packs bytes into little-endian 32-bit words and keeps a running XOR of every byte.
// word_valid pulses for one cycle after the fourth byte of each word.
module imem_loader_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        din_valid,
    input  logic [7:0]  din,
    output logic [1:0]  byte_cnt,
    output logic [7:0]  csum,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [23:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt   <= 2'd0;
            csum       <= 8'd0;
            sr_q       <= 24'd0;
            word_valid <= 1'b0;
            word       <= 32'd0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_cnt <= 2'd0;
                csum     <= 8'd0;
            end else if (din_valid) begin
                byte_cnt <= byte_cnt + 2'd1;
                csum     <= csum ^ din;
                // Newest byte enters at the top so the first byte ends up in [7:0].
                sr_q     <= {din, sr_q[23:8]};
                if (byte_cnt == 2'd3) begin
                    word       <= {din, sr_q};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: A5, count, N little-endian words, XOR checksum.
// Writes each word to IMEM and holds the CPU until a load completes cleanly.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000,
    parameter logic        HOLD_AT_RESET  = 1'b0
) (
    input  logic          clk,
    input  logic          reset_n,
    imem_loader_if.master bus,
    output state_t        dbg_state
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  word_cnt_q;
    logic [31:0]       addr_q;
    logic [23:0]       tcnt_q;
    logic              hold_q;
    logic              done_q;

    logic              busy, start, data_byte, last_word, chk_ok, chk_bad, timeout;
    logic [1:0]        byte_cnt;
    logic [7:0]        csum;
    logic              word_valid;
    logic [31:0]       word;

    imem_loader_packer u_packer (
        .clk        (clk),
        .rst_n      (reset_n),
        .clear      (start),
        .din_valid  (data_byte),
        .din        (bus.rx_data),
        .byte_cnt   (byte_cnt),
        .csum       (csum),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = COUNT;
            COUNT: begin
                if (timeout)           state_d = ERR;
                else if (bus.rx_valid) state_d = DATA;
            end
            DATA: begin
                if (timeout)        state_d = ERR;
                else if (last_word) state_d = CHECK;
            end
            CHECK: begin
                if (timeout || chk_bad) state_d = ERR;
                else if (chk_ok)        state_d = IDLE;
            end
            ERR:     if (start) state_d = COUNT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == COUNT) || (state_q == DATA) || (state_q == CHECK);
        start     = bus.rx_valid && (bus.rx_data == SYNC_BYTE) &&
                    ((state_q == IDLE) || (state_q == ERR));
        data_byte = bus.rx_valid && (state_q == DATA);
        last_word = data_byte && (byte_cnt == 2'd3) && (word_cnt_q == count_q - 9'd1);
        chk_ok    = bus.rx_valid && (state_q == CHECK) && (bus.rx_data == csum);
        chk_bad   = bus.rx_valid && (state_q == CHECK) && (bus.rx_data != csum);
        // A byte arriving in the expiry cycle wins, hence the !rx_valid term.
        timeout   = busy && !bus.rx_valid && (tcnt_q == TIMEOUT_CYCLES - 24'd1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= '0;
            word_cnt_q <= '0;
            addr_q     <= BASE_ADDR;
            tcnt_q     <= 24'd0;
            hold_q     <= HOLD_AT_RESET;
            done_q     <= 1'b0;
        end else begin
            done_q <= chk_ok;
            if (state_q == COUNT && bus.rx_valid)
                count_q <= decode_count(bus.rx_data);
            if (start)
                word_cnt_q <= '0;
            else if (data_byte && byte_cnt == 2'd3)
                word_cnt_q <= word_cnt_q + 9'd1;
            if (start)
                addr_q <= BASE_ADDR;
            else if (word_valid)
                addr_q <= addr_q + 32'd4;
            if (bus.rx_valid || !busy || timeout)
                tcnt_q <= 24'd0;
            else
                tcnt_q <= tcnt_q + 24'd1;
            if (start)
                hold_q <= 1'b1;
            else if (chk_ok)
                hold_q <= 1'b0;
        end
    end

    assign bus.imem_we    = word_valid;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = word;
    assign bus.cpu_hold   = hold_q;
    assign bus.load_busy  = busy;
    assign bus.load_done  = done_q;
    assign bus.load_error = (state_q == ERR);
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are built from word lists, expected writes
// go into a queue, and a negedge monitor compares every IMEM write against it.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0000;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if bus();
  state_t dbg_state;

  imem_loader #(
    .BASE_ADDR      (BASE),
    .TIMEOUT_CYCLES (24'd16),
    .HOLD_AT_RESET  (1'b0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // scoreboard state
  int passed = 0;
  int total = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  int done_cnt = 0;
  logic prev_we = 1'b0;
  logic [31:0] last_addr = 32'h0;
  logic [31:0] pay[256];
  logic [7:0] fb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // every write must match the head of the expected queue, never back-to-back
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.load_done) done_cnt++;
      if (bus.imem_we) begin
        check("we_spacing", {31'b0, prev_we}, 32'h0);
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_write: addr %h data %h, expected no write", bus.imem_addr, bus.imem_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_addr", bus.imem_addr, mon_e[63:32]);
          check("write_data", bus.imem_wdata, mon_e[31:0]);
        end
        last_addr = bus.imem_addr;
      end
      prev_we = bus.imem_we;
    end else begin
      prev_we = 1'b0;
    end
  end

  // driver tasks (all start and end just after a negedge)
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_range(input int lo, input int hi, input int gap);
    for (int i = lo; i <= hi; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = fb[i];
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = SYNC_BYTE;  // junk while not valid must be ignored
      repeat (gap) @(negedge clk);
    end
  endtask

  // model: frame bytes and expected writes straight from the frame rules
  task automatic build_frame(input int n, input bit bad);
    logic [7:0] cs;
    logic [31:0] w;
    logic [31:0] nn;
    cs = 8'h00;
    nn = n;
    fb.delete();
    fb.push_back(SYNC_BYTE);
    fb.push_back(nn[7:0]);
    for (int i = 0; i < n; i++) begin
      w = pay[i];
      for (int k = 0; k < 4; k++) begin
        fb.push_back(w[8*k +: 8]);
        cs = cs ^ w[8*k +: 8];
      end
      exp_q.push_back({BASE + 32'(4 * i), w});
    end
    fb.push_back(bad ? ~cs : cs);
  endtask

  task automatic check_status(input string tag, input bit busy, input bit hold, input bit err);
    check({tag, "_busy"}, {31'b0, bus.load_busy}, {31'b0, busy});
    check({tag, "_hold"}, {31'b0, bus.cpu_hold}, {31'b0, hold});
    check({tag, "_error"}, {31'b0, bus.load_error}, {31'b0, err});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"}, {31'b0, bus.imem_we}, 32'h0);
    check({tag, "_addr"}, bus.imem_addr, BASE);
    check({tag, "_wdata"}, bus.imem_wdata, 32'h0);
    check({tag, "_done"}, {31'b0, bus.load_done}, 32'h0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    check_status(tag, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    idle(2);
    check_reset_values("reset");
    reset_n = 1'b1;
    idle(1);

    // good frame, back-to-back; XOR of 03 00 04 20 03 00 00 0C is 0x28
    fb = '{8'hA5, 8'h02, 8'h03, 8'h00, 8'h04, 8'h20, 8'h03, 8'h00, 8'h00, 8'h0C, 8'h28};
    exp_q.push_back({32'h0000_0000, 32'h2004_0003});
    exp_q.push_back({32'h0000_0004, 32'h0C00_0003});
    send_range(0, 1, 0);
    check_status("hdr", 1'b1, 1'b1, 1'b0);
    send_range(2, 10, 0);
    check("done_pulse", {31'b0, bus.load_done}, 32'h1);
    idle(2);
    check("good_queue", exp_q.size(), 0);
    check("good_done", done_cnt, 1);
    check_status("good", 1'b0, 1'b0, 1'b0);

    // bad checksum: words still written, error sticky, CPU held
    fb = '{8'hA5, 8'h02, 8'h03, 8'h00, 8'h04, 8'h20, 8'h03, 8'h00, 8'h00, 8'h0C, 8'h00};
    exp_q.push_back({32'h0000_0000, 32'h2004_0003});
    exp_q.push_back({32'h0000_0004, 32'h0C00_0003});
    send_range(0, 10, 0);
    idle(2);
    check("bad_queue", exp_q.size(), 0);
    check("bad_done", done_cnt, 1);
    check("bad_state", 32'(dbg_state), 32'(ERR));
    check_status("bad", 1'b0, 1'b1, 1'b1);

    // recovery frame with spaced bytes
    pay[0] = 32'hDEAD_BEEF; pay[1] = 32'h0123_4567; pay[2] = 32'hFFFF_0000;
    build_frame(3, 1'b0);
    send_range(0, fb.size() - 1, 1);
    idle(2);
    check("rec_queue", exp_q.size(), 0);
    check("rec_done", done_cnt, 2);
    check_status("rec", 1'b0, 1'b0, 1'b0);

    // idle noise then a normal frame
    fb = '{8'h00, 8'hFF, 8'h5A};
    send_range(0, 2, 0);
    idle(1);
    check_status("noise", 1'b0, 1'b0, 1'b0);
    pay[0] = 32'h8000_0001;
    build_frame(1, 1'b0);
    send_range(0, fb.size() - 1, 2);
    idle(2);
    check("noise_done", done_cnt, 3);
    check_status("after_noise", 1'b0, 1'b0, 1'b0);

    // timeout: 16 idle cycles after the last byte
    fb = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'hA6};
    send_range(0, 3, 0);
    idle(15);
    check_status("tmo_15", 1'b1, 1'b1, 1'b0);
    idle(1);
    check_status("tmo_16", 1'b0, 1'b1, 1'b1);
    send_range(4, 5, 0);
    idle(2);
    check_status("tmo_late", 1'b0, 1'b1, 1'b1);
    check("tmo_done", done_cnt, 3);

    // N=0: 256 words
    for (int i = 0; i < 256; i++) pay[i] = (32'(i) * 32'h0101_0101) ^ 32'h5A00_00C3;
    build_frame(256, 1'b0);
    send_range(0, fb.size() - 1, 0);
    idle(2);
    check("n0_last_addr", last_addr, BASE + 32'h0000_03FC);
    check("n0_queue", exp_q.size(), 0);
    check("n0_done", done_cnt, 4);
    check_status("n0", 1'b0, 1'b0, 1'b0);

    // reset after the second word of a 4-word frame
    pay[0] = 32'h1111_1111; pay[1] = 32'h2222_2222; pay[2] = 32'h3333_3333; pay[3] = 32'h4444_4444;
    build_frame(4, 1'b0);
    send_range(0, 9, 0);
    idle(2);
    check("rst_pending", exp_q.size(), 2);
    exp_q.delete();
    reset_n = 1'b0;
    #1;
    check_reset_values("midrst");
    idle(1);
    reset_n = 1'b1;
    idle(1);
    check_reset_values("postrst");
    pay[0] = 32'hCAFE_F00D; pay[1] = 32'h0BAD_C0DE;
    build_frame(2, 1'b0);
    send_range(0, fb.size() - 1, 0);
    idle(2);
    check("rst_queue", exp_q.size(), 0);
    check("rst_last_addr", last_addr, BASE + 32'h0000_0004);
    check("rst_done", done_cnt, 5);
    check_status("rst_frame", 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
